// File: rtl/inst_byte_decoder_pkg.sv
// Shared constants for the byte-serial x86 decoder: opcodes, FSM encoding, field lengths.
package inst_byte_decoder_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned FIELD_W = 32;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned FLEN_W  = 2;

   // Supported primary opcodes
   localparam logic [7:0] OPC_ADD_RM      = 8'h01;
   localparam logic [7:0] OPC_OR_RM       = 8'h09;
   localparam logic [7:0] OPC_ADD_EAX_I32 = 8'h05;
   localparam logic [7:0] OPC_OR_EAX_I32  = 8'h0D;
   localparam logic [7:0] OPC_GRP1_I32    = 8'h81;
   localparam logic [7:0] OPC_GRP1_I8     = 8'h83;
   localparam logic [7:0] OPC_GRP2_I8     = 8'hC1;
   localparam logic [7:0] OPC_JMP_REL8    = 8'hEB;
   localparam logic [7:0] OPC_JMP_REL32   = 8'hE9;
   localparam logic [7:0] OPC_CALL_REL32  = 8'hE8;
   localparam logic [7:0] NOP_OPC_DEF     = 8'h90;

   // FSM state encoding
   localparam logic [STATE_W-1:0] ST_OPC   = 3'd0;
   localparam logic [STATE_W-1:0] ST_MODRM = 3'd1;
   localparam logic [STATE_W-1:0] ST_DISP  = 3'd2;
   localparam logic [STATE_W-1:0] ST_IMM   = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   // Field length codes
   localparam logic [FLEN_W-1:0] FLEN_0 = 2'd0;
   localparam logic [FLEN_W-1:0] FLEN_1 = 2'd1;
   localparam logic [FLEN_W-1:0] FLEN_4 = 2'd2;

   // First state still owed bytes, given which fields remain
   function automatic logic [STATE_W-1:0] next_field(input logic             need_modrm,
                                                     input logic [FLEN_W-1:0] dlen,
                                                     input logic [FLEN_W-1:0] ilen);
      logic [STATE_W-1:0] st;
      if (need_modrm)           st = ST_MODRM;
      else if (dlen != FLEN_0)  st = ST_DISP;
      else if (ilen != FLEN_0)  st = ST_IMM;
      else                      st = ST_DONE;
      return st;
   endfunction

   // True when the byte at index cnt completes a field of length flen
   function automatic logic field_last(input logic [FLEN_W-1:0] flen,
                                       input logic [CNT_W-1:0]  cnt);
      return (flen == FLEN_1) || (cnt == 2'd3);
   endfunction

   // Insert one byte: 1-byte fields land in the top byte, 4-byte fields little-endian
   function automatic logic [FIELD_W-1:0] place_byte(input logic [FIELD_W-1:0] field,
                                                     input logic [BYTE_W-1:0]  b,
                                                     input logic [FLEN_W-1:0]  flen,
                                                     input logic [CNT_W-1:0]   cnt);
      logic [FIELD_W-1:0] r;
      r = field;
      if (flen == FLEN_1) r[31:24] = b;
      else                r[{cnt, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/inst_byte_decoder_len_lut.sv
// Combinational length/legality table: opcode (+ ModRM once present) -> field lengths.
module inst_len_lut
   import inst_byte_decoder_pkg::*;
#(
   parameter logic [7:0] NOP_OPC = NOP_OPC_DEF
) (
   input  logic [7:0] opc,
   input  logic [7:0] modrm,
   input  logic       modrm_vld,
   output logic       needs_modrm,
   output logic [1:0] disp_len,
   output logic [1:0] imm_len,
   output logic       illegal
);

   logic       reg_ok;
   logic [1:0] mod_f;
   logic [2:0] reg_f;
   logic [2:0] rm_f;

   assign mod_f = modrm[7:6];
   assign reg_f = modrm[5:3];
   assign rm_f  = modrm[2:0];

   // Opcode classification, then ModRM addressing/legality when the ModRM byte is on the bus
   always_comb begin
      needs_modrm = 1'b0;
      disp_len    = FLEN_0;
      imm_len     = FLEN_0;
      illegal     = 1'b0;
      reg_ok      = 1'b1;
      case (opc)
         OPC_ADD_RM, OPC_OR_RM: begin
            needs_modrm = 1'b1;
         end
         OPC_ADD_EAX_I32, OPC_OR_EAX_I32: begin
            imm_len = FLEN_4;
         end
         OPC_GRP1_I32: begin
            needs_modrm = 1'b1;
            imm_len     = FLEN_4;
            reg_ok      = (reg_f == 3'd0) || (reg_f == 3'd1);
         end
         OPC_GRP1_I8: begin
            needs_modrm = 1'b1;
            imm_len     = FLEN_1;
            reg_ok      = (reg_f == 3'd0) || (reg_f == 3'd1);
         end
         OPC_GRP2_I8: begin
            needs_modrm = 1'b1;
            imm_len     = FLEN_1;
            reg_ok      = (reg_f == 3'd5);
         end
         OPC_JMP_REL8: begin
            disp_len = FLEN_1;
         end
         OPC_JMP_REL32, OPC_CALL_REL32: begin
            disp_len = FLEN_4;
         end
         NOP_OPC: begin
            disp_len = FLEN_0;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase

      if (needs_modrm && modrm_vld) begin
         if ((mod_f == 2'b00) && (rm_f == 3'b101)) disp_len = FLEN_4;
         else if (mod_f == 2'b01)                  disp_len = FLEN_1;
         else if (mod_f == 2'b10)                  disp_len = FLEN_4;
         else                                      disp_len = FLEN_0;
         // SIB addressing is not supported
         if (((rm_f == 3'b100) && (mod_f != 2'b11)) || !reg_ok) illegal = 1'b1;
      end
   end

endmodule

// File: rtl/inst_byte_decoder.sv
// Byte-serial x86 decoder: one byte per handshake in, one decoded record per take out.
module inst_byte_decoder
   import inst_byte_decoder_pkg::*;
#(
   parameter int unsigned LEN_W   = 4,
   parameter logic [7:0]  NOP_OPC = NOP_OPC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       opcode,
   output logic [7:0]       modrm,
   output logic             has_modrm,
   output logic [31:0]      disp,
   output logic [31:0]      imm,
   output logic [LEN_W-1:0] len,
   output logic             illegal
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FLEN_W-1:0]  disp_len_q, disp_len_d;
   logic [FLEN_W-1:0]  imm_len_q, imm_len_d;
   logic               out_valid_q, out_valid_d;
   logic [7:0]         opcode_q, opcode_d;
   logic [7:0]         modrm_q, modrm_d;
   logic               has_modrm_q, has_modrm_d;
   logic [31:0]        disp_q, disp_d;
   logic [31:0]        imm_q, imm_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               illegal_q, illegal_d;

   logic               opc_take;
   logic [7:0]         lut_opc;
   logic               lut_modrm_vld;
   logic               lut_needs_modrm;
   logic [FLEN_W-1:0]  lut_disp_len;
   logic [FLEN_W-1:0]  lut_imm_len;
   logic               lut_illegal;

   // Opcode slot is open when idle, or when the held record is being taken this cycle
   assign opc_take      = (state_q == ST_OPC) || ((state_q == ST_DONE) && out_ready);
   assign byte_ready    = (state_q != ST_DONE) || out_ready;
   assign lut_opc       = opc_take ? byte_in : opcode_q;
   assign lut_modrm_vld = (state_q == ST_MODRM);

   inst_len_lut #(
      .NOP_OPC (NOP_OPC)
   ) u_len_lut (
      .opc         (lut_opc),
      .modrm       (byte_in),
      .modrm_vld   (lut_modrm_vld),
      .needs_modrm (lut_needs_modrm),
      .disp_len    (lut_disp_len),
      .imm_len     (lut_imm_len),
      .illegal     (lut_illegal)
   );

   // Next-state and field-register update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      disp_len_d  = disp_len_q;
      imm_len_d   = imm_len_q;
      opcode_d    = opcode_q;
      modrm_d     = modrm_q;
      has_modrm_d = has_modrm_q;
      disp_d      = disp_q;
      imm_d       = imm_q;
      len_d       = len_q;
      illegal_d   = illegal_q;

      if (opc_take) begin
         if (state_q == ST_DONE) state_d = ST_OPC;
         if (byte_valid) begin
            opcode_d    = byte_in;
            modrm_d     = 8'h00;
            has_modrm_d = lut_needs_modrm;
            disp_d      = 32'h0;
            imm_d       = 32'h0;
            illegal_d   = lut_illegal;
            len_d       = LEN_W'(1);
            cnt_d       = 2'd0;
            disp_len_d  = lut_disp_len;
            imm_len_d   = lut_imm_len;
            state_d     = lut_illegal ? ST_DONE
                                      : next_field(lut_needs_modrm, lut_disp_len, lut_imm_len);
         end
      end else begin
         case (state_q)
            ST_MODRM: begin
               if (byte_valid) begin
                  modrm_d    = byte_in;
                  len_d      = len_q + LEN_W'(1);
                  disp_len_d = lut_disp_len;
                  illegal_d  = lut_illegal;
                  state_d    = lut_illegal ? ST_DONE
                                           : next_field(1'b0, lut_disp_len, imm_len_q);
               end
            end
            ST_DISP: begin
               if (byte_valid) begin
                  disp_d = place_byte(disp_q, byte_in, disp_len_q, cnt_q);
                  len_d  = len_q + LEN_W'(1);
                  if (field_last(disp_len_q, cnt_q)) begin
                     cnt_d   = 2'd0;
                     state_d = next_field(1'b0, FLEN_0, imm_len_q);
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end
            end
            ST_IMM: begin
               if (byte_valid) begin
                  imm_d = place_byte(imm_q, byte_in, imm_len_q, cnt_q);
                  len_d = len_q + LEN_W'(1);
                  if (field_last(imm_len_q, cnt_q)) begin
                     cnt_d   = 2'd0;
                     state_d = ST_DONE;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_OPC;
            end
         endcase
      end

      out_valid_d = (state_d == ST_DONE);
   end

   // State and record registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_OPC;
         cnt_q       <= 2'd0;
         disp_len_q  <= FLEN_0;
         imm_len_q   <= FLEN_0;
         out_valid_q <= 1'b0;
         opcode_q    <= 8'h00;
         modrm_q     <= 8'h00;
         has_modrm_q <= 1'b0;
         disp_q      <= 32'h0;
         imm_q       <= 32'h0;
         len_q       <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         disp_len_q  <= disp_len_d;
         imm_len_q   <= imm_len_d;
         out_valid_q <= out_valid_d;
         opcode_q    <= opcode_d;
         modrm_q     <= modrm_d;
         has_modrm_q <= has_modrm_d;
         disp_q      <= disp_d;
         imm_q       <= imm_d;
         len_q       <= len_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign opcode    = opcode_q;
   assign modrm     = modrm_q;
   assign has_modrm = has_modrm_q;
   assign disp      = disp_q;
   assign imm       = imm_q;
   assign len       = len_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_inst_byte_decoder.sv
// Directed bench for inst_byte_decoder with hand-computed expected records.
module tb_inst_byte_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  opcode;
   logic [7:0]  modrm;
   logic        has_modrm;
   logic [31:0] disp;
   logic [31:0] imm;
   logic [3:0]  len;
   logic        illegal;

   int n_tests = 0;
   int n_fail  = 0;

   inst_byte_decoder #(.LEN_W(4), .NOP_OPC(8'h90)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .opcode     (opcode),
      .modrm      (modrm),
      .has_modrm  (has_modrm),
      .disp       (disp),
      .imm        (imm),
      .len        (len),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one byte, hold it until accepted (bounded), return 1 time unit after the accepting edge
   task automatic send(input logic [7:0] b);
      int waits;
      waits      = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      @(negedge clk);
      while (!byte_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      chk("send_accept_timeout", 32'(byte_ready), 32'h1);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rec(input string tag, input logic [7:0] e_opc, input logic [7:0] e_modrm,
                          input logic e_has, input logic [31:0] e_disp, input logic [31:0] e_imm,
                          input logic [3:0] e_len, input logic e_ill);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'h1);
      chk({tag, ".opcode"},    32'(opcode),    32'(e_opc));
      chk({tag, ".modrm"},     32'(modrm),     32'(e_modrm));
      chk({tag, ".has_modrm"}, 32'(has_modrm), 32'(e_has));
      chk({tag, ".disp"},      disp,           e_disp);
      chk({tag, ".imm"},       imm,            e_imm);
      chk({tag, ".len"},       32'(len),       32'(e_len));
      chk({tag, ".illegal"},   32'(illegal),   32'(e_ill));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".out_valid"},  32'(out_valid),  32'h0);
      chk({tag, ".byte_ready"}, 32'(byte_ready), 32'h1);
      chk({tag, ".opcode"},     32'(opcode),     32'h0);
      chk({tag, ".modrm"},      32'(modrm),      32'h0);
      chk({tag, ".has_modrm"},  32'(has_modrm),  32'h0);
      chk({tag, ".disp"},       disp,            32'h0);
      chk({tag, ".imm"},        imm,             32'h0);
      chk({tag, ".len"},        32'(len),        32'h0);
      chk({tag, ".illegal"},    32'(illegal),    32'h0);
   endtask

   initial begin
      rst        = 1'b1;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      out_ready  = 1'b1;
      tick();
      tick();
      chk_reset("reset");
      rst = 1'b0;

      // 01 D8: reg-reg add, no disp/imm
      send(8'h01);
      send(8'hD8);
      chk_rec("add_rr", 8'h01, 8'hD8, 1'b1, 32'h0, 32'h0, 4'd2, 1'b0);
      tick();
      chk("add_rr.taken", 32'(out_valid), 32'h0);

      // 81 /0 with disp8 and imm32
      send(8'h81); send(8'h45); send(8'h10);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      chk_rec("grp1_i32", 8'h81, 8'h45, 1'b1, 32'h1000_0000, 32'h1234_5678, 4'd7, 1'b0);
      tick();

      // E9 rel32 held by back-pressure, EB waiting behind it
      out_ready = 1'b0;
      send(8'hE9); send(8'h04); send(8'h03); send(8'h02); send(8'h01);
      byte_in    = 8'hEB;
      byte_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("jmp32_hold.byte_ready", 32'(byte_ready), 32'h0);
         chk_rec("jmp32_hold", 8'hE9, 8'h00, 1'b0, 32'h0102_0304, 32'h0, 4'd5, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("jmp32_take.byte_ready", 32'(byte_ready), 32'h1);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      chk("jmp8_start.out_valid", 32'(out_valid), 32'h0);
      chk("jmp8_start.opcode",    32'(opcode),    32'hEB);
      chk("jmp8_start.len",       32'(len),       32'h1);
      send(8'hFE);
      chk_rec("jmp8", 8'hEB, 8'h00, 1'b0, 32'hFE00_0000, 32'h0, 4'd2, 1'b0);

      // Three NOPs back-to-back, one record per cycle
      send(8'h90);
      chk_rec("nop0", 8'h90, 8'h00, 1'b0, 32'h0, 32'h0, 4'd1, 1'b0);
      send(8'h90);
      chk_rec("nop1", 8'h90, 8'h00, 1'b0, 32'h0, 32'h0, 4'd1, 1'b0);
      send(8'h90);
      chk_rec("nop2", 8'h90, 8'h00, 1'b0, 32'h0, 32'h0, 4'd1, 1'b0);
      tick();
      chk("nop.drained", 32'(out_valid), 32'h0);

      // Unknown opcode, then SIB-form ModRM
      send(8'h0F);
      chk_rec("illegal_opc", 8'h0F, 8'h00, 1'b0, 32'h0, 32'h0, 4'd1, 1'b1);
      send(8'h01);
      send(8'h04);
      chk_rec("illegal_sib", 8'h01, 8'h04, 1'b1, 32'h0, 32'h0, 4'd2, 1'b1);
      tick();

      // 83 /0 mod=11 with a byte_valid gap, imm8 lands in top byte
      send(8'h83);
      tick(); tick(); tick();
      chk("stall.out_valid", 32'(out_valid), 32'h0);
      send(8'hC0);
      send(8'h05);
      chk_rec("grp1_i8", 8'h83, 8'hC0, 1'b1, 32'h0, 32'h0500_0000, 4'd3, 1'b0);
      tick();

      // 83 /2 is an unsupported group member
      send(8'h83);
      send(8'hD0);
      chk_rec("bad_reg", 8'h83, 8'hD0, 1'b1, 32'h0, 32'h0, 4'd2, 1'b1);
      tick();

      // Reset in the middle of 81 05 <disp32...>
      send(8'h81); send(8'h05); send(8'h12);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("mid_reset");
      send(8'h05); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      chk_rec("add_eax", 8'h05, 8'h00, 1'b0, 32'h0, 32'hDEAD_BEEF, 4'd5, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
